// File: rtl/ex_stage_pipe_if.sv
// Handshake and operand bundle between an execute stage and its neighbours.
// The master side drives operations in and accepts results; the slave side is the stage.
interface ex_stage_pipe_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_rs1;
  logic [XLEN-1:0]   in_rs2;
  logic [XLEN-1:0]   in_imm;
  logic              in_alu_src;
  logic [3:0]        in_alu_ctrl;
  logic [REG_AW-1:0] in_rd;
  logic              in_reg_write;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_result;
  logic [XLEN-1:0]   out_wdata;
  logic [REG_AW-1:0] out_rd;
  logic              out_reg_write;
  logic              busy;

  modport master (
    output in_valid, in_rs1, in_rs2, in_imm, in_alu_src, in_alu_ctrl, in_rd, in_reg_write,
    output out_ready,
    input  in_ready, out_valid, out_result, out_wdata, out_rd, out_reg_write, busy
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_imm, in_alu_src, in_alu_ctrl, in_rd, in_reg_write,
    input  out_ready,
    output in_ready, out_valid, out_result, out_wdata, out_rd, out_reg_write, busy
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// Single-entry execute stage: 1-cycle ALU plus an optional multi-cycle multiplier.
// Define EX_STAGE_MUL_EN to build the multiplier and its MUL_BUSY state.
module ex_stage_pipe #(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int MUL_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush,
  ex_stage_pipe_if.slave io
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  logic [XLEN-1:0]   op_a, op_b, alu_res;
  logic [SHW-1:0]    shamt;
  logic              out_free, accept, is_mul, mul_done, idle;

  logic              out_valid_q, out_valid_d;
  logic              out_reg_write_q, out_reg_write_d;
  logic [XLEN-1:0]   out_result_q, out_result_d;
  logic [XLEN-1:0]   out_wdata_q, out_wdata_d;
  logic [REG_AW-1:0] out_rd_q, out_rd_d;

  assign out_free    = !out_valid_q || io.out_ready;
  assign io.in_ready = reset_n && idle && out_free && !flush;
  assign accept      = io.in_valid && io.in_ready;

`ifdef EX_STAGE_MUL_EN
  localparam int CW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic {IDLE, MUL_BUSY} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_wdata_q, mul_wdata_d, mul_prod;
  logic [REG_AW-1:0] mul_rd_q, mul_rd_d;
  logic              mul_we_q, mul_we_d;

  // Completion fires on the cycle the counter would reach 0, giving MUL_CYCLES total latency;
  // if the output slot is blocked the counter parks at 0 until it frees.
  assign idle     = (state_q == IDLE);
  assign is_mul   = (io.in_alu_ctrl == OP_MUL);
  assign mul_prod = mul_a_q * mul_b_q;
  assign mul_done = (state_q == MUL_BUSY) && (cnt_q <= CW'(1)) && out_free;
  assign io.busy  = (state_q == MUL_BUSY);
`else
  assign idle     = 1'b1;
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign io.busy  = 1'b0;
`endif

  always_comb begin
    op_a    = io.in_rs1;
    op_b    = io.in_alu_src ? io.in_imm : io.in_rs2;
    shamt   = op_b[SHW-1:0];
    alu_res = '0;
    case (io.in_alu_ctrl)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
      OP_SLTU: alu_res = XLEN'(op_a < op_b);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    out_valid_d     = out_valid_q && !io.out_ready;
    out_reg_write_d = out_reg_write_q && !io.out_ready;
    out_result_d    = out_result_q;
    out_wdata_d     = out_wdata_q;
    out_rd_d        = out_rd_q;
`ifdef EX_STAGE_MUL_EN
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_wdata_d = mul_wdata_q;
    mul_rd_d    = mul_rd_q;
    mul_we_d    = mul_we_q;
`endif
    if (flush) begin
      out_valid_d     = 1'b0;
      out_reg_write_d = 1'b0;
`ifdef EX_STAGE_MUL_EN
      state_d = IDLE;
      cnt_d   = '0;
`endif
    end else if (accept && !is_mul) begin
      out_valid_d     = 1'b1;
      out_reg_write_d = io.in_reg_write;
      out_result_d    = alu_res;
      out_wdata_d     = io.in_rs2;
      out_rd_d        = io.in_rd;
    end
`ifdef EX_STAGE_MUL_EN
    else if (accept) begin
      state_d     = MUL_BUSY;
      cnt_d       = CW'(MUL_CYCLES - 1);
      mul_a_d     = op_a;
      mul_b_d     = op_b;
      mul_wdata_d = io.in_rs2;
      mul_rd_d    = io.in_rd;
      mul_we_d    = io.in_reg_write;
    end else if (state_q == MUL_BUSY) begin
      if (mul_done) begin
        state_d         = IDLE;
        cnt_d           = '0;
        out_valid_d     = 1'b1;
        out_reg_write_d = mul_we_q;
        out_result_d    = mul_prod;
        out_wdata_d     = mul_wdata_q;
        out_rd_d        = mul_rd_q;
      end else if (cnt_q > CW'(1)) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        cnt_d = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q     <= 1'b0;
      out_reg_write_q <= 1'b0;
      out_result_q    <= '0;
      out_wdata_q     <= '0;
      out_rd_q        <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_reg_write_q <= out_reg_write_d;
      out_result_q    <= out_result_d;
      out_wdata_q     <= out_wdata_d;
      out_rd_q        <= out_rd_d;
    end
  end

`ifdef EX_STAGE_MUL_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_wdata_q <= '0;
      mul_rd_q    <= '0;
      mul_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_wdata_q <= mul_wdata_d;
      mul_rd_q    <= mul_rd_d;
      mul_we_q    <= mul_we_d;
    end
  end
`endif

  assign io.out_valid     = out_valid_q;
  assign io.out_reg_write = out_reg_write_q;
  assign io.out_result    = out_result_q;
  assign io.out_wdata     = out_wdata_q;
  assign io.out_rd        = out_rd_q;
endmodule
